// File: rtl/disp_source_sel.sv
// Debug-word selector for the 4-digit seven-segment driver: debounced page/half buttons pick a 16-bit slice.
// Optional freeze feature enabled by defining DISP_HOLD_EN (snapshot of all four words on hold entry).

module disp_db #(
  parameter int DB_CYCLES = 1000000,
  parameter int DB_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);
  localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_st;
  logic            r_st_d;
  logic            r_pulse;
  logic [DB_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_st    <= 1'b0;
      r_st_d  <= 1'b0;
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_st_d  <= r_st;
      r_pulse <= r_st & ~r_st_d;
      // the counter only advances while the synchronized level disagrees with the accepted state
      if (r_sync2 == r_st) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_st  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pulse = r_pulse;
endmodule

module disp_source_sel #(
  parameter int DB_CYCLES = 1000000,
  parameter int DB_W      = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_page,
  input  logic        btn_half,
  input  logic        btn_hold,
  input  logic [31:0] dbg0,
  input  logic [31:0] dbg1,
  input  logic [31:0] dbg2,
  input  logic [31:0] dbg3,
  output logic [15:0] digit,
  output logic [1:0]  page,
  output logic        half,
  output logic        hold
);
  logic        w_p_page;
  logic        w_p_half;
  logic [31:0] w_word;
  logic [15:0] r_digit;
  logic [1:0]  r_page;
  logic        r_half;

  disp_db #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_page (
    .clk(clk), .rst(rst), .i_btn(btn_page), .o_pulse(w_p_page)
  );
  disp_db #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_half (
    .clk(clk), .rst(rst), .i_btn(btn_half), .o_pulse(w_p_half)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_page <= 2'd0;
      r_half <= 1'b0;
    end else if (w_p_page) begin
      r_page <= r_page + 2'd1;
      r_half <= 1'b0;
    end else if (w_p_half) begin
      r_half <= ~r_half;
    end
  end

`ifdef DISP_HOLD_EN
  logic        w_p_hold;
  logic        r_hold;
  logic [31:0] r_snap0;
  logic [31:0] r_snap1;
  logic [31:0] r_snap2;
  logic [31:0] r_snap3;

  disp_db #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_hold (
    .clk(clk), .rst(rst), .i_btn(btn_hold), .o_pulse(w_p_hold)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold  <= 1'b0;
      r_snap0 <= '0;
      r_snap1 <= '0;
      r_snap2 <= '0;
      r_snap3 <= '0;
    end else if (w_p_hold) begin
      r_hold <= ~r_hold;
      if (!r_hold) begin
        r_snap0 <= dbg0;
        r_snap1 <= dbg1;
        r_snap2 <= dbg2;
        r_snap3 <= dbg3;
      end
    end
  end

  always_comb begin
    w_word = '0;
    case (r_page)
      2'd0:    w_word = r_hold ? r_snap0 : dbg0;
      2'd1:    w_word = r_hold ? r_snap1 : dbg1;
      2'd2:    w_word = r_hold ? r_snap2 : dbg2;
      default: w_word = r_hold ? r_snap3 : dbg3;
    endcase
  end

  assign hold = r_hold;
`else
  logic w_unused_hold;
  assign w_unused_hold = btn_hold;

  always_comb begin
    w_word = '0;
    case (r_page)
      2'd0:    w_word = dbg0;
      2'd1:    w_word = dbg1;
      2'd2:    w_word = dbg2;
      default: w_word = dbg3;
    endcase
  end

  assign hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_digit <= '0;
    else     r_digit <= r_half ? w_word[31:16] : w_word[15:0];
  end

  assign digit = r_digit;
  assign page  = r_page;
  assign half  = r_half;
endmodule
